// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared types and encodings for the multicycle control FSM
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
    S_MEMWR, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] OP_DATA = 2'b00;
  localparam logic [1:0] OP_MEM  = 2'b01;
  localparam logic [1:0] OP_BR   = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // nzcv is {N, Z, C, V}; carry takes part in none of the supported conditions
  function automatic logic cond_eval(input logic [3:0] cond, input logic n, input logic z,
                                     input logic v);
    case (cond)
      COND_EQ: cond_eval = z;
      COND_NE: cond_eval = ~z;
      COND_GE: cond_eval = (n == v);
      COND_LT: cond_eval = (n != v);
      COND_GT: cond_eval = ~z & (n == v);
      COND_LE: cond_eval = z | (n != v);
      COND_AL: cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - NZCV flag register and condition evaluation
module cond_unit
  import ctrl_pkg::*;
#(
  parameter logic [3:0] FLAGS_INIT = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] i_cond,
  input  logic [3:0] i_alu_flags,
  input  logic       i_we_nz,
  input  logic       i_we_cv,
  output logic       o_cond_ex
);

  logic [3:0] r_flags;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= FLAGS_INIT;
    end else begin
      if (i_we_nz) r_flags[3:2] <= i_alu_flags[3:2];
      if (i_we_cv) r_flags[1:0] <= i_alu_flags[1:0];
    end
  end

  assign o_cond_ex = cond_eval(i_cond, r_flags[3], r_flags[2], r_flags[0]);

endmodule

// File: rtl/ctrl_fsm.sv
// rtl/ctrl_fsm.sv - multicycle processor control FSM with conditional execution
// Optional memory wait handshake enabled by defining CTRL_MEMWAIT_EN.
module ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter logic [3:0] FLAGS_INIT = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
`ifdef CTRL_MEMWAIT_EN
  input  logic       MemReady,
`endif
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl
);

  state_t     r_state, w_next;
  logic       w_mem_ready, w_cond_ex;
  logic       w_cmd_valid, w_cmd_arith, w_nowrite;
  logic [1:0] w_alu_dec;
  logic       w_pcw, w_memw, w_regw, w_irw, w_adr, w_srca;
  logic [1:0] w_res, w_srcb, w_alu;
  logic       w_we_nz, w_we_cv;

`ifdef CTRL_MEMWAIT_EN
  assign w_mem_ready = MemReady;
`else
  assign w_mem_ready = 1'b1;
`endif

  always_comb begin
    w_alu_dec   = ALU_ADD;
    w_nowrite   = 1'b1;
    w_cmd_valid = 1'b0;
    w_cmd_arith = 1'b0;
    case (Funct[4:1])
      CMD_ADD: begin w_alu_dec = ALU_ADD; w_nowrite = 1'b0; w_cmd_valid = 1'b1; w_cmd_arith = 1'b1; end
      CMD_SUB: begin w_alu_dec = ALU_SUB; w_nowrite = 1'b0; w_cmd_valid = 1'b1; w_cmd_arith = 1'b1; end
      CMD_AND: begin w_alu_dec = ALU_AND; w_nowrite = 1'b0; w_cmd_valid = 1'b1; end
      CMD_ORR: begin w_alu_dec = ALU_ORR; w_nowrite = 1'b0; w_cmd_valid = 1'b1; end
      CMD_CMP: begin w_alu_dec = ALU_SUB; w_cmd_valid = 1'b1; w_cmd_arith = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_pcw  = 1'b0;
    w_memw = 1'b0;
    w_regw = 1'b0;
    w_irw  = 1'b0;
    w_adr  = 1'b0;
    w_srca = 1'b0;
    w_res  = RES_ALUOUT;
    w_srcb = SRCB_REG;
    w_alu  = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        w_irw  = w_mem_ready;
        w_pcw  = w_mem_ready;
        w_srca = 1'b1;
        w_srcb = SRCB_FOUR;
        w_res  = RES_ALU;
        if (w_mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        w_srca = 1'b1;
        w_srcb = SRCB_FOUR;
        w_res  = RES_ALU;
        case (Op)
          OP_MEM:  w_next = S_MEMADR;
          OP_DATA: w_next = Funct[5] ? S_EXECI : S_EXECR;
          OP_BR:   w_next = S_BRANCH;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        w_srcb = SRCB_IMM;
        w_next = Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_adr = 1'b1;
        if (w_mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_res  = RES_DATA;
        w_regw = w_cond_ex;
        w_next = S_FETCH;
      end
      S_MEMWR: begin
        w_adr  = 1'b1;
        w_memw = w_cond_ex;
        if (w_mem_ready) w_next = S_FETCH;
      end
      S_EXECR: begin
        w_alu  = w_alu_dec;
        w_next = S_ALUWB;
      end
      S_EXECI: begin
        w_srcb = SRCB_IMM;
        w_alu  = w_alu_dec;
        w_next = S_ALUWB;
      end
      S_ALUWB: begin
        w_alu  = w_alu_dec;
        w_regw = w_cond_ex & ~w_nowrite;
        w_pcw  = w_cond_ex & ~w_nowrite & (Rd == 4'd15);
        w_next = S_FETCH;
      end
      S_BRANCH: begin
        w_srcb = SRCB_IMM;
        w_res  = RES_ALU;
        w_pcw  = w_cond_ex;
        w_next = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Unsupported commands never touch the flags, even with the S bit set
  assign w_we_nz = (r_state == S_ALUWB) & Funct[0] & w_cond_ex & w_cmd_valid;
  assign w_we_cv = w_we_nz & w_cmd_arith;

  cond_unit #(.FLAGS_INIT(FLAGS_INIT)) u_cond (
    .clk        (clk),
    .reset      (reset),
    .i_cond     (Cond),
    .i_alu_flags(ALUFlags),
    .i_we_nz    (w_we_nz),
    .i_we_cv    (w_we_cv),
    .o_cond_ex  (w_cond_ex)
  );

  assign PCWrite    = w_pcw  & ~reset;
  assign MemWrite   = w_memw & ~reset;
  assign RegWrite   = w_regw & ~reset;
  assign IRWrite    = w_irw  & ~reset;
  assign AdrSrc     = w_adr  & ~reset;
  assign ALUSrcA    = w_srca & ~reset;
  assign ResultSrc  = reset ? 2'b00 : w_res;
  assign ALUSrcB    = reset ? 2'b00 : w_srcb;
  assign ALUControl = reset ? 2'b00 : w_alu;
  assign ImmSrc     = reset ? 2'b00 : Op;
  assign RegSrc     = reset ? 2'b00 : {Op == OP_MEM, Op == OP_BR};

endmodule

// File: tb/tb_ctrl_fsm.sv
// tb/tb_ctrl_fsm.sv - self-checking bench for ctrl_fsm (vector table, hand sequences, random vs model)
module tb_ctrl_fsm;
  import ctrl_pkg::*;

  localparam logic [3:0] FINIT = 4'b0000;

  logic       clk = 1'b0;
  logic       reset;
  logic       MemReady;
  logic [3:0] Cond, Rd, ALUFlags;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;

  typedef struct packed {
    logic       pcw, memw, regw, irw, adr, srca;
    logic [1:0] res, srcb, imm, regsrc, alu;
  } ctl_t;

  typedef struct {
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] af;
    int         len, regw, memw, pcw;
    logic [3:0] flags;
  } vec_t;

  ctl_t act;
  assign act = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
                ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl};

  int         checks = 0;
  int         failures = 0;
  ctl_t       exp_q[$];
  logic [3:0] m_flags;
  logic       m_ce;
  vec_t       tbl[15];

  always #5 clk = ~clk;

  ctrl_fsm #(.FLAGS_INIT(FINIT)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef CTRL_MEMWAIT_EN
    .MemReady  (MemReady),
`endif
    .Cond      (Cond),
    .Op        (Op),
    .Funct     (Funct),
    .Rd        (Rd),
    .ALUFlags  (ALUFlags),
    .PCWrite   (PCWrite),
    .MemWrite  (MemWrite),
    .RegWrite  (RegWrite),
    .IRWrite   (IRWrite),
    .AdrSrc    (AdrSrc),
    .ALUSrcA   (ALUSrcA),
    .ResultSrc (ResultSrc),
    .ALUSrcB   (ALUSrcB),
    .ImmSrc    (ImmSrc),
    .RegSrc    (RegSrc),
    .ALUControl(ALUControl)
  );

  task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, a, e);
    end
  endtask

  function automatic logic m_condex(input logic [3:0] c, input logic [3:0] f);
    logic n, z, v;
    n = f[3]; z = f[2]; v = f[0];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Expected per-cycle control words for one instruction, from the instruction-class rules
  task automatic build_exp(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                           input logic [3:0] r, input logic [3:0] fl);
    ctl_t b, x;
    logic [1:0] alu;
    logic nw;
    m_ce = m_condex(c, fl);
    case (f[4:1])
      4'b0100: begin alu = 2'd0; nw = 1'b0; end
      4'b0010: begin alu = 2'd1; nw = 1'b0; end
      4'b0000: begin alu = 2'd2; nw = 1'b0; end
      4'b1100: begin alu = 2'd3; nw = 1'b0; end
      4'b1010: begin alu = 2'd1; nw = 1'b1; end
      default: begin alu = 2'd0; nw = 1'b1; end
    endcase
    exp_q.delete();
    b = '0; b.imm = o; b.regsrc = {o == 2'b01, o == 2'b10};
    x = b; x.irw = 1; x.pcw = 1; x.srca = 1; x.srcb = 2; x.res = 2; exp_q.push_back(x);
    x = b; x.srca = 1; x.srcb = 2; x.res = 2; exp_q.push_back(x);
    if (o == 2'b00) begin
      x = b; x.srcb = f[5] ? 2'd1 : 2'd0; x.alu = alu; exp_q.push_back(x);
      x = b; x.alu = alu; x.regw = m_ce && !nw; x.pcw = m_ce && !nw && (r == 4'd15); exp_q.push_back(x);
    end else if (o == 2'b01) begin
      x = b; x.srcb = 1; exp_q.push_back(x);
      if (f[0]) begin
        x = b; x.adr = 1; exp_q.push_back(x);
        x = b; x.res = 1; x.regw = m_ce; exp_q.push_back(x);
      end else begin
        x = b; x.adr = 1; x.memw = m_ce; exp_q.push_back(x);
      end
    end else if (o == 2'b10) begin
      x = b; x.srcb = 1; x.res = 2; x.pcw = m_ce; exp_q.push_back(x);
    end
  endtask

  function automatic logic [3:0] m_next_flags(input logic [1:0] o, input logic [5:0] f,
                                             input logic [3:0] a, input logic [3:0] fl,
                                             input logic ce);
    logic [3:0] nf;
    logic valid, arith;
    nf = fl;
    valid = (f[4:1] == 4'b0100) || (f[4:1] == 4'b0010) || (f[4:1] == 4'b0000) ||
            (f[4:1] == 4'b1100) || (f[4:1] == 4'b1010);
    arith = (f[4:1] == 4'b0100) || (f[4:1] == 4'b0010) || (f[4:1] == 4'b1010);
    if (o == 2'b00 && f[0] && ce && valid) begin
      nf[3:2] = a[3:2];
      if (arith) nf[1:0] = a[1:0];
    end
    return nf;
  endfunction

  // Entered mid-FETCH; returns at the negedge of the following FETCH
  task automatic run_instr(input string nm, input logic [3:0] c, input logic [1:0] o,
                           input logic [5:0] f, input logic [3:0] r, input logic [3:0] a,
                           output int len, output int nrw, output int nmw, output int npw);
    int i;
    Cond = c; Op = o; Funct = f; Rd = r; ALUFlags = a;
    build_exp(c, o, f, r, m_flags);
    nrw = 0; nmw = 0; npw = 0; i = 0;
    #1;
    for (int k = 0; k < 10; k++) begin
      if (i < exp_q.size()) check({nm, " ctl"}, 32'(act), 32'(exp_q[i]));
      else check({nm, " overrun"}, 32'(act), 32'hFFFF_FFFF);
      nrw += int'(RegWrite); nmw += int'(MemWrite); npw += int'(PCWrite);
      @(posedge clk); @(negedge clk);
      i++;
      if (IRWrite === 1'b1) break;
    end
    len = i;
    check({nm, " len"}, len, exp_q.size());
    m_flags = m_next_flags(o, f, a, m_flags, m_ce);
    check({nm, " flags"}, 32'(dut.u_cond.r_flags), 32'(m_flags));
  endtask

  initial begin
    int len, nrw, nmw, npw;
    logic [3:0] cmds[6];
    cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010, 4'b0111};

    tbl[0]  = '{4'hE, 2'd0, 6'b001000, 4'd1,  4'b0000, 4, 1, 0, 1, 4'b0000};
    tbl[1]  = '{4'hE, 2'd1, 6'b011001, 4'd2,  4'b0000, 5, 1, 0, 1, 4'b0000};
    tbl[2]  = '{4'hE, 2'd1, 6'b011000, 4'd2,  4'b0000, 4, 0, 1, 1, 4'b0000};
    tbl[3]  = '{4'hE, 2'd0, 6'b010101, 4'd0,  4'b0100, 4, 0, 0, 1, 4'b0100};
    tbl[4]  = '{4'h0, 2'd2, 6'b000000, 4'd0,  4'b0000, 3, 0, 0, 2, 4'b0100};
    tbl[5]  = '{4'h1, 2'd2, 6'b000000, 4'd0,  4'b0000, 3, 0, 0, 1, 4'b0100};
    tbl[6]  = '{4'h1, 2'd0, 6'b000101, 4'd3,  4'b1011, 4, 0, 0, 1, 4'b0100};
    tbl[7]  = '{4'hE, 2'd0, 6'b001000, 4'd15, 4'b0000, 4, 1, 0, 2, 4'b0100};
    tbl[8]  = '{4'hE, 2'd0, 6'b100001, 4'd4,  4'b1011, 4, 1, 0, 1, 4'b1000};
    tbl[9]  = '{4'hE, 2'd3, 6'b000000, 4'd0,  4'b0000, 2, 0, 0, 1, 4'b1000};
    tbl[10] = '{4'hE, 2'd0, 6'b011111, 4'd5,  4'b1111, 4, 0, 0, 1, 4'b1000};
    tbl[11] = '{4'hA, 2'd0, 6'b001001, 4'd6,  4'b0011, 4, 0, 0, 1, 4'b1000};
    tbl[12] = '{4'hB, 2'd0, 6'b001001, 4'd6,  4'b0011, 4, 1, 0, 1, 4'b0011};
    tbl[13] = '{4'hC, 2'd0, 6'b011000, 4'd7,  4'b0000, 4, 0, 0, 1, 4'b0011};
    tbl[14] = '{4'hD, 2'd0, 6'b011001, 4'd7,  4'b0101, 4, 1, 0, 1, 4'b0111};

    reset = 1'b1; MemReady = 1'b1;
    Cond = 4'hE; Op = 2'b01; Funct = 6'b011001; Rd = 4'd15; ALUFlags = 4'hF;
    m_flags = FINIT;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset outputs", 32'(act), 32'h0);
    check("reset flags", 32'(dut.u_cond.r_flags), 32'(FINIT));
    reset = 1'b0;

    foreach (tbl[t]) begin
      run_instr($sformatf("vec%0d", t), tbl[t].cond, tbl[t].op, tbl[t].funct, tbl[t].rd,
                tbl[t].af, len, nrw, nmw, npw);
      check($sformatf("vec%0d len", t), len, tbl[t].len);
      check($sformatf("vec%0d regw", t), nrw, tbl[t].regw);
      check($sformatf("vec%0d memw", t), nmw, tbl[t].memw);
      check($sformatf("vec%0d pcw", t), npw, tbl[t].pcw);
      check($sformatf("vec%0d flags", t), 32'(dut.u_cond.r_flags), 32'(tbl[t].flags));
    end

    // STR aborted by reset while in MEMWR
    Cond = 4'hE; Op = 2'b01; Funct = 6'b011000; Rd = 4'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("memwr before reset", 32'(MemWrite), 32'd1);
    #2 reset = 1'b1;
    #1 check("memwr on reset", 32'(MemWrite), 32'd0);
    check("outputs on reset", 32'(act), 32'h0);
    @(posedge clk); @(negedge clk);
    check("outputs reset held", 32'(act), 32'h0);
    check("flags after reset", 32'(dut.u_cond.r_flags), 32'(FINIT));
    reset = 1'b0;
    #1 check("fetch after release", 32'({IRWrite, PCWrite}), 32'b11);
    m_flags = FINIT;

    for (int n = 0; n < 300; n++) begin
      logic [5:0] f;
      f = {1'($urandom), cmds[$urandom_range(0, 5)], 1'($urandom)};
      run_instr($sformatf("rnd%0d", n), 4'($urandom), 2'($urandom), f, 4'($urandom),
                4'($urandom), len, nrw, nmw, npw);
    end

`ifdef CTRL_MEMWAIT_EN
    Cond = 4'hE; Op = 2'b00; Funct = 6'b001000; Rd = 4'd1;
    MemReady = 1'b0;
    #1;
    for (int w = 0; w < 3; w++) begin
      check("wait irwrite", 32'({IRWrite, PCWrite}), 32'b00);
      check("wait selects", 32'({ALUSrcA, ALUSrcB, ResultSrc}), 32'b11010);
      @(posedge clk); @(negedge clk);
    end
    MemReady = 1'b1;
    #1 check("ready irwrite", 32'({IRWrite, PCWrite}), 32'b11);
    @(posedge clk); @(negedge clk);
    check("after ready state", 32'(dut.r_state), 32'(S_DECODE));
    check("after ready irwrite", 32'(IRWrite), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
